// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Holds the program counter, drives the byte address
// of the instruction memory and registers the returned 32-bit word into the
// IF/ID pipeline register. Supports hazard stall, branch redirect with flush,
// and a HALT state entered when HALT_INSTR is captured.
//
// Optional feature macro: FETCH_COUNT_EN
//   When defined, adds a 32-bit fetch_count output counting every cycle in
//   which IF/ID is loaded with a valid instruction (wraps at 2^32).
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] NOP_INSTR  = 32'hD503201F,
    parameter logic [31:0] HALT_INSTR = 32'hD4400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [64:0] imem_address,
    input  logic [31:0] imem_data,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fetch_fault
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    // BOOT covers the single cycle after reset release in which no capture
    // happens; RUN is normal fetch; HALT freezes the PC until a redirect.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        fetch_fault_q, fetch_fault_d;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
`endif

    // Next-state and next-register computation; redirect wins over everything.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        fetch_fault_d = 1'b0;
`ifdef FETCH_COUNT_EN
        fetch_count_d = fetch_count_q;
`endif

        if (branch_taken) begin
            // Redirect and flush in any state; stall does not block it.
            // The low two target bits are dropped and flagged as a fault.
            pc_d          = {branch_target[63:2], 2'b00};
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            fetch_fault_d = |branch_target[1:0];
            state_d       = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!stall) begin
                        if_id_instr_d = imem_data;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
`ifdef FETCH_COUNT_EN
                        fetch_count_d = fetch_count_q + 32'd1;
`endif
                        // A captured halt keeps the PC pointing at itself.
                        if (imem_data == HALT_INSTR) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d = pc_q + 64'd4;
                        end
                    end
                end
                ST_HALT: begin
                    // Bubble the pipeline; re-applying it every HALT cycle is
                    // equivalent to doing it only on the first one.
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // State and pipeline registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
`ifdef FETCH_COUNT_EN
            fetch_count_q <= 32'h0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_fault_q <= fetch_fault_d;
`ifdef FETCH_COUNT_EN
            fetch_count_q <= fetch_count_d;
`endif
        end
    end

    assign imem_address = {1'b0, pc_q};
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_valid  = if_id_valid_q;
    assign fetch_fault  = fetch_fault_q;
    assign halted       = (state_q == ST_HALT);
`ifdef FETCH_COUNT_EN
    assign fetch_count  = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Table-driven bench for fetch_stage. Each vector holds the inputs for one
// clock and the outputs expected right after that edge; the expected record is
// queued when the inputs are driven and popped when the outputs are sampled.
// Hand-written sequences cover reset state and asynchronous reset in HALT.
// Compile with +define+FETCH_COUNT_EN to also check fetch_count.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'hD503201F;
    localparam logic [31:0] HALT = 32'hD4400000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [64:0] imem_address;
    logic [31:0] imem_data;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_fault;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC  (64'h0),
        .NOP_INSTR (NOP),
        .HALT_INSTR(HALT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_address (imem_address),
        .imem_data    (imem_data),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_fault  (fetch_fault)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // 256-byte little-endian instruction memory, aliased on address[7:0].
    logic [7:0] mem [256];
    logic [7:0] ma;
    assign ma        = imem_address[7:0];
    assign imem_data = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    task automatic put_word(input logic [7:0] addr, input logic [31:0] w);
        mem[addr]         = w[7:0];
        mem[addr + 8'd1]  = w[15:8];
        mem[addr + 8'd2]  = w[23:16];
        mem[addr + 8'd3]  = w[31:24];
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic        fault;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[26];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic s, input logic b, input logic [63:0] t,
                                input logic [63:0] pc, input logic [63:0] ipc,
                                input logic [31:0] ins, input logic v, input logic h,
                                input logic f, input logic [31:0] c);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.pc = pc; r.ipc = ipc;
        r.instr = ins; r.valid = v; r.halted = h; r.fault = f; r.cnt = c;
        return r;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag, input vec_t e);
        check({tag, " addr"},  imem_address, {1'b0, e.pc});
        check({tag, " ipc"},   {1'b0, if_id_pc}, {1'b0, e.ipc});
        check({tag, " instr"}, {33'h0, if_id_instr}, {33'h0, e.instr});
        check({tag, " valid"}, {64'h0, if_id_valid}, {64'h0, e.valid});
        check({tag, " halted"}, {64'h0, halted}, {64'h0, e.halted});
        check({tag, " fault"}, {64'h0, fetch_fault}, {64'h0, e.fault});
`ifdef FETCH_COUNT_EN
        check({tag, " count"}, {33'h0, fetch_count}, {33'h0, e.cnt});
`endif
    endtask

    // Drive one vector, clock once, then compare against the queued record.
    task automatic apply(input int idx);
        vec_t e;
        stall         = vecs[idx].stall;
        branch_taken  = vecs[idx].br;
        branch_target = vecs[idx].tgt;
        exp_q.push_back(vecs[idx]);
        @(posedge clk);
        #1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard empty", idx);
        end else begin
            e = exp_q.pop_front();
            compare_all($sformatf("v%0d", idx), e);
        end
    endtask

    initial begin
        vec_t rst_exp;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        put_word(8'h00, 32'h8B020020);
        put_word(8'h04, 32'h8B030041);
        put_word(8'h08, 32'h8B040062);
        put_word(8'h0C, 32'h8B050083);
        put_word(8'h10, HALT);
        put_word(8'h40, 32'hAA000001);
        put_word(8'h44, 32'hAA000002);
        put_word(8'hFC, 32'h11223344);

        //           st br tgt                    pc                     ipc                    instr         v  h  f  cnt
        vecs[0]  = mk(0, 0, 64'h0,                64'h0,                 64'h0,                 NOP,          0, 0, 0, 0);  // BOOT
        vecs[1]  = mk(0, 0, 64'h0,                64'h4,                 64'h0,                 32'h8B020020, 1, 0, 0, 1);
        vecs[2]  = mk(0, 0, 64'h0,                64'h8,                 64'h4,                 32'h8B030041, 1, 0, 0, 2);
        vecs[3]  = mk(1, 0, 64'h0,                64'h8,                 64'h4,                 32'h8B030041, 1, 0, 0, 2);  // stall x3
        vecs[4]  = mk(1, 0, 64'h0,                64'h8,                 64'h4,                 32'h8B030041, 1, 0, 0, 2);
        vecs[5]  = mk(1, 0, 64'h0,                64'h8,                 64'h4,                 32'h8B030041, 1, 0, 0, 2);
        vecs[6]  = mk(0, 0, 64'h0,                64'hC,                 64'h8,                 32'h8B040062, 1, 0, 0, 3);
        vecs[7]  = mk(1, 1, 64'h40,               64'h40,                64'h8,                 NOP,          0, 0, 0, 3);  // branch+stall
        vecs[8]  = mk(0, 0, 64'h0,                64'h44,                64'h40,                32'hAA000001, 1, 0, 0, 4);
        vecs[9]  = mk(0, 1, 64'h42,               64'h40,                64'h40,                NOP,          0, 0, 1, 4);  // misaligned
        vecs[10] = mk(0, 0, 64'h0,                64'h44,                64'h40,                32'hAA000001, 1, 0, 0, 5);
        vecs[11] = mk(0, 1, 64'hC,                64'hC,                 64'h40,                NOP,          0, 0, 0, 5);
        vecs[12] = mk(0, 0, 64'h0,                64'h10,                64'hC,                 32'h8B050083, 1, 0, 0, 6);
        vecs[13] = mk(0, 0, 64'h0,                64'h10,                64'h10,                HALT,         1, 1, 0, 7);  // halt captured
        vecs[14] = mk(1, 0, 64'h0,                64'h10,                64'h10,                NOP,          0, 1, 0, 7);  // stall ignored
        vecs[15] = mk(0, 0, 64'h0,                64'h10,                64'h10,                NOP,          0, 1, 0, 7);
        vecs[16] = mk(0, 1, 64'h0,                64'h0,                 64'h10,                NOP,          0, 0, 0, 7);  // leave HALT
        vecs[17] = mk(0, 0, 64'h0,                64'h4,                 64'h0,                 32'h8B020020, 1, 0, 0, 8);
        vecs[18] = mk(1, 1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,  64'h0,                 NOP,          0, 0, 1, 8);
        vecs[19] = mk(0, 0, 64'h0,                64'h0,                 64'hFFFFFFFFFFFFFFFC,  32'h11223344, 1, 0, 0, 9);  // pc wrap
        vecs[20] = mk(0, 0, 64'h0,                64'h4,                 64'h0,                 32'h8B020020, 1, 0, 0, 10);
        vecs[21] = mk(0, 1, 64'h10,               64'h10,                64'h0,                 NOP,          0, 0, 0, 10);
        vecs[22] = mk(0, 0, 64'h0,                64'h10,                64'h10,                HALT,         1, 1, 0, 11);
        vecs[23] = mk(0, 0, 64'h0,                64'h10,                64'h10,                NOP,          0, 1, 0, 11);
        vecs[24] = mk(0, 1, 64'h44,               64'h44,                64'h0,                 NOP,          0, 0, 0, 0);  // branch in BOOT
        vecs[25] = mk(0, 0, 64'h0,                64'h48,                64'h44,                32'hAA000002, 1, 0, 0, 1);

        rst_exp = mk(0, 0, 64'h0, 64'h0, 64'h0, NOP, 0, 0, 0, 0);

        // Power-on reset.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset", rst_exp);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) apply(i);

        // Asynchronous reset mid-cycle while in HALT: outputs clear before any edge.
        check("pre-rst halted", {64'h0, halted}, {64'h0, 1'b1});
        #2 rst = 1'b1;
        #1;
        compare_all("async-rst", rst_exp);
        @(posedge clk);
        #1;
        compare_all("rst-held", rst_exp);
        rst = 1'b0;

        for (int i = 24; i < 26; i++) apply(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
